// File: rtl/mem_load_unit.sv
// mem_load_unit
//   Single-outstanding load unit. Accepts a byte/halfword/word load request,
//   checks its alignment, reads one aligned word from memory with a fixed
//   latency, then extracts and extends the addressed lane.
//
// Ports
//   clk         in   1   clock, all state on rising edge
//   reset       in   1   synchronous active-high reset
//   start       in   1   load request, sampled only while busy=0
//   load_type   in   2   00 word, 01 halfword, 10 byte, 11 reserved (error)
//   sign_ext    in   1   1 sign-extend, 0 zero-extend (halfword/byte)
//   addr        in   32  byte address of the load
//   mem_addr    out  32  word-aligned memory address (holds between reads)
//   mem_rd_en   out  1   memory read enable, high for the whole wait window
//   mem_rdata   in   32  memory read data, MEM_LATENCY cycles after mem_addr
//   busy        out  1   transaction in progress
//   done        out  1   one-cycle completion pulse
//   load_data   out  32  extended result, holds until the next done
//   misaligned  out  1   error flag, meaningful while done=1
module mem_load_unit #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  load_type,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY);

    localparam logic [1:0] LT_WORD = 2'b00;
    localparam logic [1:0] LT_HALF = 2'b01;
    localparam logic [1:0] LT_BYTE = 2'b10;

    logic [1:0]  state;
    logic [3:0]  cnt;

    // Operands latched at acceptance; only the byte offset is needed after
    // the memory address has been issued.
    logic [1:0]  off_q;
    logic [1:0]  type_q;
    logic        sext_q;
    logic        err_q;
    logic [31:0] rdata_p0;

    logic        accept;
    logic        req_ok;
    logic        last_wait;

    // Reserved load_type falls through to "not aligned" and is reported
    // through the same error path as a misaligned access.
    function automatic logic is_aligned(input logic [1:0] lt, input logic [1:0] a);
        case (lt)
            LT_WORD: is_aligned = (a == 2'b00);
            LT_HALF: is_aligned = (a[0] == 1'b0);
            LT_BYTE: is_aligned = 1'b1;
            default: is_aligned = 1'b0;
        endcase
    endfunction

    // Little-endian lane select followed by sign or zero extension.
    // sign_ext is irrelevant for full words.
    function automatic logic [31:0] extend_load(input logic [1:0]  lt,
                                                input logic        sx,
                                                input logic [1:0]  off,
                                                input logic [31:0] rd);
        logic signed [15:0] h;
        logic signed [7:0]  b;
        logic signed [31:0] r;
        h = off[1] ? rd[31:16] : rd[15:0];
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        case (lt)
            LT_WORD: r = rd;
            LT_HALF: r = sx ? 32'(h) : {16'h0, h};
            LT_BYTE: r = sx ? 32'(b) : {24'h0, b};
            default: r = 32'sh0;
        endcase
        extend_load = r;
    endfunction

    assign accept    = (state == IDLE) && start;
    assign req_ok    = is_aligned(load_type, addr[1:0]);
    assign last_wait = (state == WAIT) && (cnt == 4'd1);

    assign busy      = (state != IDLE);
    assign mem_rd_en = (state == WAIT);

    // Stage p0: operand latch at acceptance, read data at end of the wait window
    always_ff @(posedge clk) begin
        if (accept) begin
            off_q  <= addr[1:0];
            type_q <= load_type;
            sext_q <= sign_ext;
            err_q  <= !req_ok;
        end
        if (last_wait) begin
            rdata_p0 <= mem_rdata;
        end
    end

    // Control FSM and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            done       <= 1'b0;
            mem_addr   <= 32'h0;
            load_data  <= 32'h0;
            misaligned <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= LAT_INIT;
                        if (req_ok) begin
                            mem_addr <= {addr[31:2], 2'b00};
                            state    <= WAIT;
                        end else begin
                            // Error requests skip the memory entirely.
                            state <= CAPTURE;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    if (err_q) begin
                        load_data  <= 32'h0;
                        misaligned <= 1'b1;
                    end else begin
                        load_data  <= extend_load(type_q, sext_q, off_q, rdata_p0);
                        misaligned <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_load_unit.sv
module tb_mem_load_unit;

    localparam int LAT = 2;
    localparam logic [31:0] JUNK = 32'h5A5A_A5A5;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  load_type;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        misaligned;

    int errors = 0;
    int checks = 0;

    mem_load_unit #(.MEM_LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_type  (load_type),
        .sign_ext   (sign_ext),
        .addr       (addr),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [1:0]  lt;
        logic        sx;
        logic [31:0] rd;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one load and follows it to its done pulse. mem_rdata carries the
    // real word only during the cycle that ends at edge E0+LAT.
    task automatic run_load(input vec_t v);
        int          k;
        int          rd_cycles;
        int          done_at;
        logic [31:0] prev_maddr;
        logic [31:0] exp_maddr;
        logic        err;
        err        = v.exp_mis;
        exp_maddr  = {v.a[31:2], 2'b00};
        prev_maddr = mem_addr;
        rd_cycles  = 0;
        done_at    = 0;
        @(negedge clk);
        start     = 1'b1;
        addr      = v.a;
        load_type = v.lt;
        sign_ext  = v.sx;
        @(posedge clk);
        #1;
        // Scramble operands after acceptance; they must not matter.
        start     = 1'b0;
        addr      = ~v.a;
        load_type = ~v.lt;
        sign_ext  = ~v.sx;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            mem_rdata = (k == LAT) ? v.rd : JUNK;
            // A start while busy must be ignored.
            start = (k == 1);
            if (mem_rd_en) begin
                rd_cycles++;
                check({v.name, " mem_addr"}, mem_addr, exp_maddr);
            end
            if (done) begin
                done_at = k;
                break;
            end
        end
        start     = 1'b0;
        mem_rdata = JUNK;
        check({v.name, " done_cycle"}, 32'(done_at), err ? 32'd2 : 32'(LAT + 2));
        check({v.name, " rd_cycles"}, 32'(rd_cycles), err ? 32'd0 : 32'(LAT));
        check({v.name, " load_data"}, load_data, v.exp_data);
        check({v.name, " misaligned"}, {31'h0, misaligned}, {31'h0, v.exp_mis});
        check({v.name, " busy_at_done"}, {31'h0, busy}, 32'h0);
        if (err) check({v.name, " mem_addr_hold"}, mem_addr, prev_maddr);
        @(negedge clk);
        check({v.name, " done_one_cycle"}, {31'h0, done}, 32'h0);
        check({v.name, " no_queued_start"}, {31'h0, busy}, 32'h0);
        check({v.name, " data_holds"}, load_data, v.exp_data);
    endtask

    initial begin
        vecs[0]  = '{"word",        32'h0000_0104, 2'b00, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{"byte3_sx",    32'h0000_0103, 2'b10, 1'b1, 32'h80FF_7F01, 32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{"byte3_zx",    32'h0000_0103, 2'b10, 1'b0, 32'h80FF_7F01, 32'h0000_0080, 1'b0};
        vecs[3]  = '{"half_hi_sx",  32'h0000_0202, 2'b01, 1'b1, 32'h8001_1234, 32'hFFFF_8001, 1'b0};
        vecs[4]  = '{"half_lo_sx",  32'h0000_0200, 2'b01, 1'b1, 32'h8001_1234, 32'h0000_1234, 1'b0};
        vecs[5]  = '{"half_mis",    32'h0000_0201, 2'b01, 1'b1, 32'h8001_1234, 32'h0000_0000, 1'b1};
        vecs[6]  = '{"reserved",    32'h0000_0200, 2'b11, 1'b0, 32'h8001_1234, 32'h0000_0000, 1'b1};
        vecs[7]  = '{"word_mis",    32'h0000_0106, 2'b00, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
        vecs[8]  = '{"word_sx",     32'h0000_0010, 2'b00, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0};
        vecs[9]  = '{"byte1_sx",    32'h0000_0101, 2'b10, 1'b1, 32'h80FF_7F01, 32'h0000_007F, 1'b0};
        vecs[10] = '{"byte2_sx",    32'h0000_0102, 2'b10, 1'b1, 32'h80FF_7F01, 32'hFFFF_FFFF, 1'b0};
        vecs[11] = '{"half_hi_zx",  32'h0000_0202, 2'b01, 1'b0, 32'h8001_1234, 32'h0000_8001, 1'b0};

        reset     = 1'b1;
        start     = 1'b1;   // reset must win over start
        load_type = 2'b00;
        sign_ext  = 1'b0;
        addr      = 32'h0000_0104;
        mem_rdata = JUNK;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy",       {31'h0, busy},       32'h0);
        check("rst done",       {31'h0, done},       32'h0);
        check("rst mem_rd_en",  {31'h0, mem_rd_en},  32'h0);
        check("rst mem_addr",   mem_addr,            32'h0);
        check("rst load_data",  load_data,           32'h0);
        check("rst misaligned", {31'h0, misaligned}, 32'h0);
        start = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_load(vecs[i]);

        // Back-to-back: start held high; second request accepted on the done edge.
        begin
            int seen_done;
            seen_done = 0;
            @(negedge clk);
            start = 1'b1; addr = 32'h0000_0104; load_type = 2'b00; sign_ext = 1'b0;
            for (int c = 1; c <= 9; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    addr = 32'h0000_0103; load_type = 2'b10; sign_ext = 1'b0;
                end
                if (c == 5) start = 1'b0;
                mem_rdata = (c == 2) ? 32'hDEAD_BEEF : (c == 6) ? 32'h80FF_7F01 : JUNK;
                if (done) seen_done++;
                if (c == 4) begin
                    check("b2b first done", {31'h0, done}, 32'h1);
                    check("b2b first data", load_data, 32'hDEAD_BEEF);
                end
                if (c == 5) begin
                    check("b2b second busy",  {31'h0, busy},      32'h1);
                    check("b2b second rd_en", {31'h0, mem_rd_en}, 32'h1);
                    check("b2b second addr",  mem_addr,           32'h0000_0100);
                end
                if (c == 8) begin
                    check("b2b second done", {31'h0, done}, 32'h1);
                    check("b2b second data", load_data, 32'h0000_0080);
                end
            end
            check("b2b done count", 32'(seen_done), 32'd2);
            mem_rdata = JUNK;
        end

        // Reset during WAIT aborts without a done pulse.
        begin
            int seen_done;
            seen_done = 0;
            @(negedge clk);
            start = 1'b1; addr = 32'h0000_0104; load_type = 2'b00; sign_ext = 1'b0;
            @(negedge clk);
            start = 1'b0;
            check("abort in_wait", {31'h0, mem_rd_en}, 32'h1);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("abort busy",     {31'h0, busy},      32'h0);
            check("abort rd_en",    {31'h0, mem_rd_en}, 32'h0);
            check("abort mem_addr", mem_addr,           32'h0);
            for (int c = 0; c < 4; c++) begin
                if (done) seen_done++;
                if (c < 3) @(negedge clk);
            end
            check("abort no done", 32'(seen_done), 32'd0);
        end
        begin
            vec_t v;
            v = '{"post_rst_byte", 32'h0000_0000, 2'b10, 1'b0, 32'h0000_00AB, 32'h0000_00AB, 1'b0};
            run_load(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_load_unit.md
MEM_LOAD_UNIT -- requirements
Module: mem_load_unit

Interface
REQ-001 Parameter MEM_LATENCY, default 2, SHALL be the memory read latency in cycles from mem_addr valid to mem_rdata valid; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  load request, sampled only when busy=0.
REQ-005 load_type  input  2  00 word, 01 halfword, 10 byte, 11 reserved.
REQ-006 sign_ext  input  1  1 = sign-extend, 0 = zero-extend (halfword/byte only).
REQ-007 addr  input  32  byte address of the load.
REQ-008 mem_addr  output  32  word-aligned memory address.
REQ-009 mem_rd_en  output  1  memory read enable.
REQ-010 mem_rdata  input  32  memory read data.
REQ-011 busy  output  1  transaction in progress.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 load_data  output  32  extended result bound for the register-file write-data path.
REQ-014 misaligned  output  1  error flag; valid only while done=1.

Function
REQ-015 States SHALL be IDLE, WAIT, CAPTURE; busy=1 in WAIT and CAPTURE, 0 in IDLE.
REQ-016 In IDLE with start=1, the block SHALL latch addr, load_type and sign_ext at that edge (E0).
REQ-017 An aligned request SHALL go to WAIT, and an error request SHALL go to CAPTURE with no memory access.
REQ-018 Aligned means word with addr[1:0]=00, halfword with addr[0]=0, or any byte.
REQ-019 load_type=11 SHALL be treated as an error.
REQ-020 In WAIT, mem_rd_en SHALL be 1 and mem_addr SHALL be {addr_q[31:2],2'b00}; elsewhere mem_rd_en=0 and mem_addr SHALL hold its last value.
REQ-021 A down-counter loaded with MEM_LATENCY at E0 SHALL decrement each WAIT cycle, and WAIT SHALL leave for CAPTURE when the counter reaches 1.
REQ-022 mem_rdata SHALL be sampled at edge E0+MEM_LATENCY.
REQ-023 CAPTURE SHALL last one cycle, then go to IDLE.
REQ-024 At the CAPTURE->IDLE edge, done SHALL be set for exactly one cycle, and load_data and misaligned SHALL be updated at the same edge.
REQ-025 Aligned latency: done=1 in the cycle after edge E0+MEM_LATENCY+1.
REQ-026 Error latency: done=1 in the cycle after edge E0+1.
REQ-027 Byte order SHALL be little-endian: byte k = mem_rdata[8k+7:8k], k = addr_q[1:0].
REQ-028 Halfword SHALL be mem_rdata[15:0] if addr_q[1]=0, else mem_rdata[31:16].
REQ-029 Word SHALL be mem_rdata unchanged, and sign_ext SHALL be ignored for word loads.
REQ-030 Halfword and byte results SHALL be sign-extended from bit 15/7 when sign_ext=1, else zero-filled.
REQ-031 On error, load_data SHALL be 32'h0 and misaligned SHALL be 1.
REQ-032 On success, misaligned SHALL be 0.
REQ-033 load_data SHALL hold until the next done.
REQ-034 Back-to-back: start in the cycle where done=1 (state IDLE) SHALL be accepted, giving a new transaction with no idle gap.
REQ-035 start while busy=1 SHALL be ignored, not queued, and SHALL NOT alter latched operands.
REQ-036 Input changes on addr, load_type and sign_ext after E0 SHALL NOT affect the in-flight transaction.

Reset
REQ-037 While reset=1 at a clock edge, the state SHALL become IDLE and counter=0.
REQ-038 Under reset: busy=0, done=0, mem_rd_en=0, mem_addr=0, load_data=0, misaligned=0.
REQ-039 Reset SHALL take priority over start in the same cycle.
REQ-040 Reset mid-transaction SHALL abort it with no done pulse, and the block SHALL accept start in the first cycle after reset deasserts.

Verification
REQ-041 Word load, MEM_LATENCY=2: start, addr=0x0000_0104, mem_rdata=0xDEAD_BEEF -> mem_addr=0x0000_0104 and mem_rd_en=1 for 2 cycles; done one cycle after edge E0+3, load_data=0xDEAD_BEEF, misaligned=0.
REQ-042 Byte load with sign extension: addr=0x0000_0103, mem_rdata=0x80FF_7F01, sign_ext=1 -> load_data=0xFFFF_FF80; repeated with sign_ext=0 -> 0x0000_0080.
REQ-043 Halfword upper: addr=0x0000_0202, mem_rdata=0x8001_1234, sign_ext=1 -> 0xFFFF_8001.
REQ-044 Halfword lower: addr=0x0000_0200, mem_rdata=0x8001_1234, sign_ext=1 -> 0x0000_1234.
REQ-045 Misaligned halfword at addr=0x0000_0201 -> mem_rd_en never 1; done one cycle after edge E0+1 with misaligned=1, load_data=0.
REQ-046 Reserved load_type=11 -> same error response as REQ-045.
REQ-047 Back-to-back: start held high across done -> second transaction's E0 is the done cycle's edge; start pulses during busy have no effect.
REQ-048 Reset during WAIT -> next cycle busy=0, mem_rd_en=0, no done pulse.
REQ-049 After the reset in REQ-048, a new byte load at addr=0x0000_0000 with mem_rdata=0x0000_00AB, sign_ext=0 -> load_data=0x0000_00AB.
